// File: rtl/run_gen_pkg.sv
// Shared types and default sizes for the run-length stream generator.
// A run command is one bit value plus the number of times it repeats.
package run_gen_pkg;

    localparam int LEN_W_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int DET_N_DEF      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic                 bit_v;
        logic [LEN_W_DEF-1:0] len;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a fall-through head word.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module cmd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer update; reset discards every buffered command.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1'b1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1'b1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/run_stream_gen.sv
// Serialises buffered {bit, length} run commands onto w and predicts the output
// of an N-in-a-row detector watching w (z_exp).
module run_stream_gen
    import run_gen_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DET_N      = DET_N_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_bit,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_w,
    output logic             o_w_valid,
    output logic             o_run_done,
    output logic             o_z_exp
);
    localparam int               RC_W   = $clog2(DET_N + 1);
    localparam logic [RC_W-1:0]  RC_MAX = RC_W'(DET_N);

    logic [LEN_W:0]   w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_emit;
    logic             w_emit_bit;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_w;
    logic             w_w_nxt;
    logic             r_w_valid;
    logic             w_w_valid_nxt;
    logic [RC_W-1:0]  r_rc;
    logic [RC_W-1:0]  w_rc_nxt;
    logic             r_lb;
    logic             w_lb_nxt;

    cmd_fifo #(
        .WIDTH (LEN_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_cmd_valid && o_cmd_ready),
        .i_pop   (w_pop),
        .i_data  ({i_cmd_bit, i_cmd_len}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_cmd_ready = !w_full && !i_rst;

    // Next-state, bit-stream and run-tracking logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_w_nxt       = r_w;
        w_w_valid_nxt = r_w_valid;
        w_rc_nxt      = r_rc;
        w_lb_nxt      = r_lb;
        w_pop         = 1'b0;
        w_emit        = 1'b0;
        w_emit_bit    = r_w;

        case (r_state)
            IDLE: begin
                w_w_valid_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_pop = 1'b0;
                end
            end
            SEND: begin
                if (r_cnt != {LEN_W{1'b0}}) begin
                    w_cnt_nxt = r_cnt - LEN_W'(1'b1);
                    w_emit    = 1'b1;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_w_valid_nxt = 1'b0;
            end
        endcase

        // A popped null command is dropped, costing a single bubble cycle.
        if (w_pop) begin
            if (w_head[LEN_W-1:0] != {LEN_W{1'b0}}) begin
                w_state_nxt = SEND;
                w_emit      = 1'b1;
                w_emit_bit  = w_head[LEN_W];
                w_cnt_nxt   = w_head[LEN_W-1:0] - LEN_W'(1'b1);
            end else begin
                w_state_nxt   = IDLE;
                w_w_valid_nxt = 1'b0;
            end
        end else begin
            w_emit_bit = w_emit_bit;
        end

        // Idle cycles leave rc/lb untouched so a run may span several commands.
        if (w_emit) begin
            w_w_nxt       = w_emit_bit;
            w_w_valid_nxt = 1'b1;
            w_lb_nxt      = w_emit_bit;
            if ((w_emit_bit == r_lb) && (r_rc != {RC_W{1'b0}})) begin
                w_rc_nxt = (r_rc == RC_MAX) ? RC_MAX : (r_rc + RC_W'(1'b1));
            end else begin
                w_rc_nxt = RC_W'(1'b1);
            end
        end else begin
            w_lb_nxt = r_lb;
        end
    end

    // State and output registers; reset abandons any run in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= {LEN_W{1'b0}};
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_rc      <= {RC_W{1'b0}};
            r_lb      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_w       <= w_w_nxt;
            r_w_valid <= w_w_valid_nxt;
            r_rc      <= w_rc_nxt;
            r_lb      <= w_lb_nxt;
        end
    end

    assign o_w        = r_w;
    assign o_w_valid  = r_w_valid;
    assign o_run_done = r_w_valid && (r_cnt == {LEN_W{1'b0}});
    assign o_z_exp    = r_w_valid && (r_rc == RC_MAX);

endmodule
